// File: rtl/msrv32_target_addr_unit.sv
// Target address unit: computes branch / jump / JALR / link addresses and
// carries them through PIPE_DEPTH elastic register stages.
//
// Ports:
//   ms_riscv32_mp_clk_in  - clock, all state on the rising edge
//   ms_riscv32_mp_rst_in  - asynchronous active-low reset
//   flush_in              - squash every in-flight result at the next edge
//   valid_in / ready_out  - upstream handshake for {pc_in, rs_1_in, imm_in, mode_in}
//   mode_in               - 00 pc+imm, 01 rs1+imm, 10 (rs1+imm)&~1, 11 pc+LINK_OFFSET
//   valid_out / ready_in  - downstream handshake for {iadder_out, misaligned_out}
//   iadder_out            - computed target address
//   misaligned_out        - target violates IALIGN (qualified by valid_out)
module msrv32_target_addr_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_DEPTH  = 1,
    parameter int unsigned IALIGN      = 32,
    parameter int unsigned LINK_OFFSET = 4
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs_1_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [1:0]      mode_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] iadder_out,
    output logic            misaligned_out
);

    // ------------------------------------------------------------------
    // Stage 0: address arithmetic and alignment check
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            target_mis;

    always_comb begin
        op_a = pc_in;
        op_b = imm_in;
        unique case (mode_in)
            2'b00: begin
                op_a = pc_in;
                op_b = imm_in;
            end
            2'b01, 2'b10: begin
                op_a = rs_1_in;
                op_b = imm_in;
            end
            2'b11: begin
                op_a = pc_in;
                op_b = XLEN'(LINK_OFFSET);
            end
        endcase

        // Carry out is discarded: wrap-around targets are legal.
        sum    = op_a + op_b;
        target = sum;

        // JALR clears bit 0 before the alignment check.
        if (mode_in == 2'b10) begin
            target[0] = 1'b0;
        end

        if (IALIGN == 16) begin
            target_mis = target[0];
        end else begin
            target_mis = target[1] | target[0];
        end
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0]           v_q;
    logic [PIPE_DEPTH-1:0]           v_d;
    logic [PIPE_DEPTH-1:0][XLEN-1:0] addr_q;
    logic [PIPE_DEPTH-1:0][XLEN-1:0] addr_d;
    logic [PIPE_DEPTH-1:0]           mis_q;
    logic [PIPE_DEPTH-1:0]           mis_d;
    logic [PIPE_DEPTH-1:0]           stg_ready;
    logic                            ready_acc;

    // Index k of each chain is the upstream source of stage k; index
    // PIPE_DEPTH is the last stage, which drives the outputs.
    logic [PIPE_DEPTH:0]             chain_v;
    logic [PIPE_DEPTH:0]             chain_mis;
    logic [PIPE_DEPTH:0][XLEN-1:0]   chain_addr;

    assign chain_v    = {v_q, valid_in};
    assign chain_mis  = {mis_q, target_mis};
    assign chain_addr = {addr_q, target};

    // ready_k = !v_k | ready_(k+1), evaluated from the output end backwards.
    always_comb begin
        ready_acc = ready_in;
        stg_ready = '0;
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            ready_acc    = ready_acc | ~v_q[k];
            stg_ready[k] = ready_acc;
        end
    end

    always_comb begin
        v_d    = v_q;
        addr_d = addr_q;
        mis_d  = mis_q;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            // A ready stage is either empty or being drained, so it simply
            // takes whatever its upstream offers (possibly a bubble).
            if (stg_ready[k]) begin
                v_d[k] = chain_v[k];
                if (chain_v[k]) begin
                    addr_d[k] = chain_addr[k];
                    mis_d[k]  = chain_mis[k];
                end
            end
        end
        // Flush beats every transfer; data registers may keep stale values.
        if (flush_in) begin
            v_d = '0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            v_q    <= '0;
            addr_q <= '0;
            mis_q  <= '0;
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
            mis_q  <= mis_d;
        end
    end

    assign ready_out      = stg_ready[0];
    assign valid_out      = chain_v[PIPE_DEPTH];
    assign iadder_out     = chain_addr[PIPE_DEPTH];
    assign misaligned_out = chain_mis[PIPE_DEPTH];

endmodule

// File: tb/tb_msrv32_target_addr_unit.sv
// Scoreboard bench for msrv32_target_addr_unit. Four instances cover the
// configurations of interest:
//   0: XLEN=32 PIPE_DEPTH=2 IALIGN=32  (modes, wrap, reset, flush, latency)
//   1: XLEN=32 PIPE_DEPTH=3 IALIGN=32  (backpressure)
//   2: XLEN=64 PIPE_DEPTH=1 IALIGN=32  (64-bit wrap)
//   3: XLEN=32 PIPE_DEPTH=1 IALIGN=16  (16-bit alignment)
module tb_msrv32_target_addr_unit;

    typedef struct packed {
        logic [63:0] addr;
        logic        mis;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fl2   = 1'b0;
    logic        fl_off = 1'b0;
    logic [63:0] pc_s  = '0;
    logic [63:0] rs_s  = '0;
    logic [63:0] imm_s = '0;
    logic [1:0]  mode_s = 2'b00;
    logic [3:0]  vin = '0;
    logic [3:0]  rin = '1;
    logic [3:0]  rout;
    logic [3:0]  vout;
    logic [3:0]  mis;
    logic [31:0] a_d2;
    logic [31:0] a_d3;
    logic [63:0] a_x64;
    logic [31:0] a_a16;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e0, e1, e2, e3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msrv32_target_addr_unit #(.XLEN(32), .PIPE_DEPTH(2), .IALIGN(32), .LINK_OFFSET(4)) u_d2 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(fl2),
        .valid_in(vin[0]), .ready_out(rout[0]), .pc_in(pc_s[31:0]), .rs_1_in(rs_s[31:0]),
        .imm_in(imm_s[31:0]), .mode_in(mode_s), .valid_out(vout[0]), .ready_in(rin[0]),
        .iadder_out(a_d2), .misaligned_out(mis[0])
    );

    msrv32_target_addr_unit #(.XLEN(32), .PIPE_DEPTH(3), .IALIGN(32), .LINK_OFFSET(4)) u_d3 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(fl_off),
        .valid_in(vin[1]), .ready_out(rout[1]), .pc_in(pc_s[31:0]), .rs_1_in(rs_s[31:0]),
        .imm_in(imm_s[31:0]), .mode_in(mode_s), .valid_out(vout[1]), .ready_in(rin[1]),
        .iadder_out(a_d3), .misaligned_out(mis[1])
    );

    msrv32_target_addr_unit #(.XLEN(64), .PIPE_DEPTH(1), .IALIGN(32), .LINK_OFFSET(4)) u_x64 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(fl_off),
        .valid_in(vin[2]), .ready_out(rout[2]), .pc_in(pc_s), .rs_1_in(rs_s),
        .imm_in(imm_s), .mode_in(mode_s), .valid_out(vout[2]), .ready_in(rin[2]),
        .iadder_out(a_x64), .misaligned_out(mis[2])
    );

    msrv32_target_addr_unit #(.XLEN(32), .PIPE_DEPTH(1), .IALIGN(16), .LINK_OFFSET(4)) u_a16 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(fl_off),
        .valid_in(vin[3]), .ready_out(rout[3]), .pc_in(pc_s[31:0]), .rs_1_in(rs_s[31:0]),
        .imm_in(imm_s[31:0]), .mode_in(mode_s), .valid_out(vout[3]), .ready_in(rin[3]),
        .iadder_out(a_a16), .misaligned_out(mis[3])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected output %h with empty scoreboard (t=%0t)", nm, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [63:0] pc, input logic [63:0] rs, input logic [63:0] imm,
                          input logic [1:0] mode);
        pc_s   = pc;
        rs_s   = rs;
        imm_s  = imm;
        mode_s = mode;
    endtask

    // Present one operand set to instance 'inst', record the expected result
    // and hold valid until accepted (bounded).
    task automatic send(input logic [1:0] inst, input logic [63:0] pc, input logic [63:0] rs,
                        input logic [63:0] imm, input logic [1:0] mode,
                        input logic [63:0] ea, input logic em);
        exp_t e;
        logic acc;
        int   n;
        e.addr = ea;
        e.mis  = em;
        case (inst)
            2'd0: q0.push_back(e);
            2'd1: q1.push_back(e);
            2'd2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
        set_in(pc, rs, imm, mode);
        vin[inst] = 1'b1;
        n = 0;
        do begin
            acc = rout[inst];
            tick();
            n++;
        end while (!acc && n < 50);
        vin[inst] = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: instance %0d never ready, expected ready", inst);
        end
    endtask

    // Item accepted on the first edge must be on valid_out after the second.
    task automatic lat_check_d2(input string nm, input logic [63:0] pc, input logic [63:0] ea);
        e0 = '0;
        q0.push_back('{addr: ea, mis: 1'b0});
        set_in(pc, 64'h0, 64'h0, 2'b00);
        vin[0] = 1'b1;
        chk({nm, "_ready"}, 64'(rout[0]), 64'h1);
        tick();
        vin[0] = 1'b0;
        chk({nm, "_lat1"}, 64'(vout[0]), 64'h0);
        tick();
        chk({nm, "_lat2"}, 64'(vout[0]), 64'h1);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Monitors: pop and compare on every downstream transfer
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (vout[0] && rin[0] && !fl2) begin
            if (q0.size() == 0) unexpected("d2_out", 64'(a_d2));
            else begin
                e0 = q0.pop_front();
                chk("d2_addr", 64'(a_d2), e0.addr);
                chk("d2_mis", 64'(mis[0]), 64'(e0.mis));
            end
        end
    end

    always @(negedge clk) begin
        if (vout[1] && rin[1]) begin
            if (q1.size() == 0) unexpected("d3_out", 64'(a_d3));
            else begin
                e1 = q1.pop_front();
                chk("d3_addr", 64'(a_d3), e1.addr);
                chk("d3_mis", 64'(mis[1]), 64'(e1.mis));
            end
        end
    end

    always @(negedge clk) begin
        if (vout[2] && rin[2]) begin
            if (q2.size() == 0) unexpected("x64_out", a_x64);
            else begin
                e2 = q2.pop_front();
                chk("x64_addr", a_x64, e2.addr);
                chk("x64_mis", 64'(mis[2]), 64'(e2.mis));
            end
        end
    end

    always @(negedge clk) begin
        if (vout[3] && rin[3]) begin
            if (q3.size() == 0) unexpected("a16_out", 64'(a_a16));
            else begin
                e3 = q3.pop_front();
                chk("a16_addr", 64'(a_a16), e3.addr);
                chk("a16_mis", 64'(mis[3]), 64'(e3.mis));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        #2;
        chk("rst_valid", 64'(vout), 64'h0);
        chk("rst_ready", 64'(rout), 64'hF);
        chk("rst_addr_d2", 64'(a_d2), 64'h0);
        chk("rst_addr_x64", a_x64, 64'h0);
        chk("rst_mis", 64'(mis), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Modes and 32-bit wrap, back to back on the 2-stage instance
        send(2'd0, 64'h1000, 64'h2003, 64'h10, 2'b00, 64'h1010, 1'b0);
        send(2'd0, 64'h1000, 64'h2003, 64'h10, 2'b01, 64'h2013, 1'b1);
        send(2'd0, 64'h1000, 64'h2003, 64'h10, 2'b10, 64'h2012, 1'b1);
        send(2'd0, 64'h1000, 64'h2003, 64'h10, 2'b11, 64'h1004, 1'b0);
        send(2'd0, 64'hFFFF_FFFC, 64'h2003, 64'h8, 2'b00, 64'h4, 1'b0);
        repeat (3) tick();

        // Reset mid-stream with two items in flight
        rin[0] = 1'b0;
        send(2'd0, 64'h7000, 64'h0, 64'h4, 2'b00, 64'h7004, 1'b0);
        send(2'd0, 64'h7000, 64'h0, 64'h8, 2'b00, 64'h7008, 1'b0);
        chk("pre_rst_valid", 64'(vout[0]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vout[0]), 64'h0);
        chk("mid_rst_addr", 64'(a_d2), 64'h0);
        chk("mid_rst_ready", 64'(rout[0]), 64'h1);
        q0.delete();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rin[0] = 1'b1;
        lat_check_d2("post_rst", 64'h7100, 64'h7100);

        // Flush: two items in flight plus a valid input on the flush cycle
        rin[0] = 1'b0;
        send(2'd0, 64'h5000, 64'h0, 64'h0, 2'b00, 64'h5000, 1'b0);
        send(2'd0, 64'h5000, 64'h0, 64'h4, 2'b00, 64'h5004, 1'b0);
        chk("d2_full_ready", 64'(rout[0]), 64'h0);
        set_in(64'h5000, 64'h0, 64'h8, 2'b00);
        vin[0] = 1'b1;
        fl2 = 1'b1;
        tick();
        fl2 = 1'b0;
        vin[0] = 1'b0;
        chk("flush_valid", 64'(vout[0]), 64'h0);
        chk("flush_ready", 64'(rout[0]), 64'h1);
        q0.delete();
        rin[0] = 1'b1;
        repeat (4) tick();
        lat_check_d2("post_flush", 64'h6000, 64'h6000);

        // Backpressure on the 3-stage instance
        q1.push_back('{addr: 64'h3000, mis: 1'b0});
        q1.push_back('{addr: 64'h3011, mis: 1'b1});
        q1.push_back('{addr: 64'h3022, mis: 1'b1});
        q1.push_back('{addr: 64'h3033, mis: 1'b1});
        q1.push_back('{addr: 64'h3044, mis: 1'b0});
        rin[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(64'h3000 + 64'(16 * k), 64'h0, 64'(k), 2'b00);
            vin[1] = 1'b1;
            chk("bp_fill_ready", 64'(rout[1]), 64'h1);
            tick();
        end
        set_in(64'h3030, 64'h0, 64'h3, 2'b00);
        for (int k = 0; k < 2; k++) begin
            chk("bp_full_ready", 64'(rout[1]), 64'h0);
            chk("bp_hold_addr", 64'(a_d3), 64'h3000);
            tick();
        end
        rin[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_stream_valid", 64'(vout[1]), 64'h1);
            if (k == 1) set_in(64'h3040, 64'h0, 64'h4, 2'b00);
            if (k == 2) vin[1] = 1'b0;
            tick();
        end
        chk("bp_drained", 64'(vout[1]), 64'h0);

        // 64-bit datapath
        send(2'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 2'b01, 64'h10, 1'b0);
        send(2'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 64'h9, 2'b11, 64'h0, 1'b0);
        send(2'd2, 64'h0, 64'h1_0000_0000, 64'h7, 2'b10, 64'h1_0000_0006, 1'b1);
        repeat (2) tick();

        // 16-bit alignment
        send(2'd3, 64'h0, 64'h2000, 64'h2, 2'b01, 64'h2002, 1'b0);
        send(2'd3, 64'h0, 64'h2000, 64'h1, 2'b01, 64'h2001, 1'b1);
        send(2'd3, 64'h0, 64'h2000, 64'h1, 2'b10, 64'h2000, 1'b0);
        send(2'd3, 64'h1000, 64'h0, 64'h6, 2'b00, 64'h1006, 1'b0);
        repeat (5) tick();

        chk("q_d2_empty", 64'(q0.size()), 64'h0);
        chk("q_d3_empty", 64'(q1.size()), 64'h0);
        chk("q_x64_empty", 64'(q2.size()), 64'h0);
        chk("q_a16_empty", 64'(q3.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
